// File: rtl/led_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_engine
// Description : Turns the timer's three-phase one-hot trigger lines into LED
//               shift steps. Rotate and bounce modes, a load handshake for new
//               patterns, run/pause control and a sticky phase-sequence error.
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_engine #(
    parameter int unsigned           WIDTH        = 8,
    parameter logic [WIDTH-1:0]      INIT_PATTERN = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             trigger1,
    input  logic             trigger2,
    input  logic             trigger3,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pattern,
    input  logic             err_clear,
    output logic [WIDTH-1:0] leds,
    output logic             dir,
    output logic             busy,
    output logic             load_ack,
    output logic             phase_err,
    output logic [7:0]       step_count
);

    // prev_phase value meaning "not yet synchronised to the timer"
    localparam logic [1:0] c_PHASE_NONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_prev_phase;
    logic       r_load_seen;

    logic             w_phase_valid;
    logic [1:0]       w_phase;
    logic [1:0]       w_expected;
    logic [1:0]       w_prev_next;
    logic             w_advance;
    logic             w_seq_err;
    logic             w_accept;
    logic [WIDTH-1:0] w_shift_leds;
    logic             w_shift_dir;

    // Decode the trigger lines: exactly one high line is a valid phase.
    always_comb begin
        w_phase_valid = 1'b1;
        w_phase       = c_PHASE_NONE;
        case ({trigger3, trigger2, trigger1})
            3'b001:  w_phase = 2'd0;
            3'b010:  w_phase = 2'd1;
            3'b100:  w_phase = 2'd2;
            default: w_phase_valid = 1'b0;
        endcase
    end

    // Compare the decoded phase with the last one seen to find advances and sequence errors.
    always_comb begin
        w_expected  = (r_prev_phase == 2'd2) ? 2'd0 : r_prev_phase + 2'd1;
        w_prev_next = r_prev_phase;
        w_advance   = 1'b0;
        w_seq_err   = 1'b0;
        if (!w_phase_valid) begin
            // Invalid combination: flag it and resynchronise on the next valid phase.
            w_seq_err   = 1'b1;
            w_prev_next = c_PHASE_NONE;
        end else if (r_prev_phase == c_PHASE_NONE) begin
            w_prev_next = w_phase;
        end else if (w_phase == r_prev_phase) begin
            w_prev_next = r_prev_phase;
        end else if (w_phase == w_expected) begin
            w_advance   = 1'b1;
            w_prev_next = w_phase;
        end else begin
            w_seq_err   = 1'b1;
            w_prev_next = w_phase;
        end
    end

    // Next LED pattern and direction for one shift step in the current mode.
    always_comb begin
        w_shift_leds = leds;
        w_shift_dir  = dir;
        if (!mode) begin
            w_shift_leds = dir ? {leds[0], leds[WIDTH-1:1]}
                               : {leds[WIDTH-2:0], leds[WIDTH-1]};
        end else if (leds[WIDTH-1] && leds[0]) begin
            // Both ends lit: nowhere to bounce, so the pattern and direction hold.
            w_shift_leds = leds;
        end else begin
            // Turn around before a lit end bit would fall off, then shift that way.
            if (!dir && leds[WIDTH-1]) begin
                w_shift_dir = 1'b1;
            end else if (dir && leds[0]) begin
                w_shift_dir = 1'b0;
            end
            w_shift_leds = w_shift_dir ? {1'b0, leds[WIDTH-1:1]}
                                       : {leds[WIDTH-2:0], 1'b0};
        end
    end

    // A load is taken once per request, and never while running.
    assign w_accept = load && !r_load_seen && (r_state != S_RUN);

    // Control FSM, phase tracking, handshake and LED register update.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state      <= S_IDLE;
            r_prev_phase <= c_PHASE_NONE;
            r_load_seen  <= 1'b0;
            leds         <= INIT_PATTERN;
            dir          <= 1'b0;
            busy         <= 1'b0;
            load_ack     <= 1'b0;
            phase_err    <= 1'b0;
            step_count   <= 8'd0;
        end else begin
            r_prev_phase <= w_prev_next;
            load_ack     <= w_accept;

            // A new error on the same edge as err_clear keeps the flag set.
            if (w_seq_err) begin
                phase_err <= 1'b1;
            end else if (err_clear) begin
                phase_err <= 1'b0;
            end

            if (w_accept) begin
                r_load_seen <= 1'b1;
            end else if (!load) begin
                r_load_seen <= 1'b0;
            end

            if (w_accept) begin
                leds       <= load_pattern;
                dir        <= dir_in;
                step_count <= 8'd0;
            end else if (w_advance && (r_state == S_RUN)) begin
                leds       <= w_shift_leds;
                dir        <= w_shift_dir;
                step_count <= step_count + 8'd1;
            end

            // Priority: load, then stop, then start.
            if (w_accept) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else if (stop) begin
                if (r_state == S_RUN) begin
                    r_state <= S_PAUSE;
                    busy    <= 1'b0;
                end
            end else if (start) begin
                // An all-dark pattern has nothing to show, so IDLE refuses to start.
                if ((r_state == S_PAUSE) || ((r_state == S_IDLE) && (leds != '0))) begin
                    r_state <= S_RUN;
                    busy    <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_shift_engine
// Description : Self-checking bench for led_shift_engine with a behavioural
//               reference model and directed plus randomized scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_shift_engine;

    localparam int W        = 8;
    localparam int MASK     = (1 << W) - 1;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;

    logic         clk = 1'b0;
    logic         sync_reset, trigger1, trigger2, trigger3;
    logic         start, stop, mode, dir_in, load, err_clear;
    logic [W-1:0] load_pattern;
    logic [W-1:0] leds;
    logic         dir, busy, load_ack, phase_err;
    logic [7:0]   step_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_leds, m_dir, m_state, m_prev, m_err, m_seen, m_ack, m_cnt;
    int cur_ph;

    led_shift_engine #(.WIDTH(W), .INIT_PATTERN(8'h01)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .trigger1(trigger1), .trigger2(trigger2), .trigger3(trigger3),
        .start(start), .stop(stop), .mode(mode), .dir_in(dir_in),
        .load(load), .load_pattern(load_pattern), .err_clear(err_clear),
        .leds(leds), .dir(dir), .busy(busy), .load_ack(load_ack),
        .phase_err(phase_err), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one rising edge, computed from the current inputs.
    task automatic model_edge();
        int  n, ph, old_leds, msb;
        bit  adv, err, acc;
        msb = 1 << (W - 1);
        if (sync_reset) begin
            m_leds = 1; m_dir = 0; m_state = ST_IDLE; m_prev = 3;
            m_err = 0; m_seen = 0; m_ack = 0; m_cnt = 0;
            return;
        end
        n   = int'(trigger1) + int'(trigger2) + int'(trigger3);
        adv = 0;
        err = 0;
        if (n != 1) begin
            err = 1; m_prev = 3;
        end else begin
            ph = trigger1 ? 0 : (trigger2 ? 1 : 2);
            if (m_prev == 3) m_prev = ph;
            else if (ph == (m_prev + 1) % 3) begin adv = 1; m_prev = ph; end
            else if (ph != m_prev) begin err = 1; m_prev = ph; end
        end
        acc      = load && (m_seen == 0) && (m_state != ST_RUN);
        old_leds = m_leds;
        if (acc) begin
            m_leds = int'(load_pattern); m_dir = int'(dir_in); m_cnt = 0;
        end else if (adv && m_state == ST_RUN) begin
            if (!mode) begin
                if (m_dir == 0) m_leds = ((m_leds << 1) | (m_leds >> (W - 1))) & MASK;
                else            m_leds = (m_leds >> 1) | ((m_leds & 1) << (W - 1));
            end else if (!((m_leds & msb) != 0 && (m_leds & 1) != 0)) begin
                if (m_dir == 0 && (m_leds & msb) != 0)  m_dir = 1;
                else if (m_dir == 1 && (m_leds & 1) != 0) m_dir = 0;
                m_leds = (m_dir == 0) ? ((m_leds << 1) & MASK) : (m_leds >> 1);
            end
            m_cnt = (m_cnt + 1) % 256;
        end
        if (acc) m_state = ST_IDLE;
        else if (stop) begin
            if (m_state == ST_RUN) m_state = ST_PAUSE;
        end else if (start) begin
            if (m_state == ST_PAUSE || (m_state == ST_IDLE && old_leds != 0)) m_state = ST_RUN;
        end
        m_ack = acc ? 1 : 0;
        if (acc) m_seen = 1; else if (!load) m_seen = 0;
        if (err) m_err = 1; else if (err_clear) m_err = 0;
    endtask

    function automatic logic [W+11:0] mdl_vec();
        return {W'(m_leds), 1'(m_dir), 1'(m_state == ST_RUN), 1'(m_ack), 1'(m_err), 8'(m_cnt)};
    endfunction

    function automatic string fmt(logic [W+11:0] v);
        return $sformatf("leds=%h dir=%b busy=%b ack=%b err=%b cnt=%0d",
                         v[W+11:12], v[11], v[10], v[9], v[8], v[7:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // 0..2 one-hot phase, 3 = all low, 4 = trigger1 and trigger2 together
    task automatic set_phase(input int p);
        trigger1 = (p == 0) || (p == 4);
        trigger2 = (p == 1) || (p == 4);
        trigger3 = (p == 2);
    endtask

    task automatic advance();
        cur_ph = (cur_ph + 1) % 3;
        set_phase(cur_ph);
        tick();
    endtask

    task automatic test_reset();
        sync_reset = 1; cur_ph = 0; set_phase(0);
        tick(); tick();
        sync_reset = 0;
        n_tests++;
        if ({leds, dir, busy, load_ack, phase_err, step_count} !== {8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset: actual %s, required leds=01 dir=0 busy=0 ack=0 err=0 cnt=0",
                     fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_leds;
        mode = 0; dir_in = 0; load_pattern = 8'h01; load = 1;
        tick();
        n_tests++;
        if (load_ack !== 1'b1 || leds !== 8'h01 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL rotate_load: actual %s, required %s", fmt({leds, dir, busy, load_ack, phase_err, step_count}), fmt(mdl_vec()));
        end
        load = 0;
        tick();
        n_tests++;
        if (load_ack !== 1'b0) begin
            n_fail++; $display("FAIL rotate_ack_width: actual ack=%b, required 0", load_ack);
        end
        start = 1; tick(); start = 0;
        for (int i = 0; i < 9; i++) begin
            cur_ph = i % 3;
            set_phase(cur_ph);
            tick();
            exp_leds = 8'(1 << (i % 8));
            n_tests++;
            if (leds !== exp_leds || step_count !== 8'(i) || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rotate_step%0d: actual %s, required leds=%h cnt=%0d (%s)", i,
                         fmt({leds, dir, busy, load_ack, phase_err, step_count}), exp_leds, i, fmt(mdl_vec()));
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_l [3];
        logic       exp_d [3];
        exp_l = '{8'h80, 8'h40, 8'h20};
        exp_d = '{1'b0, 1'b1, 1'b1};
        stop = 1; tick(); stop = 0;
        mode = 1; load_pattern = 8'h40; dir_in = 0; load = 1; tick(); load = 0; tick();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++;
            if (leds !== exp_l[i] || dir !== exp_d[i] || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
                n_fail++;
                $display("FAIL bounce%0d: actual %s, required leds=%h dir=%b", i,
                         fmt({leds, dir, busy, load_ack, phase_err, step_count}), exp_l[i], exp_d[i]);
            end
        end
        stop = 1; tick(); stop = 0;
        load_pattern = 8'h81; load = 1; tick(); load = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++;
            if (leds !== 8'h81 || step_count !== 8'(i + 1) || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
                n_fail++;
                $display("FAIL bounce_hold%0d: actual %s, required leds=81 cnt=%0d", i,
                         fmt({leds, dir, busy, load_ack, phase_err, step_count}), i + 1);
            end
        end
    endtask

    task automatic test_phase_err();
        cur_ph = (cur_ph + 2) % 3;
        set_phase(cur_ph);
        tick();
        n_tests++;
        if (phase_err !== 1'b1 || step_count !== 8'd3 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL err_skip: actual %s, required err=1 cnt=3", fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
        set_phase(4);
        tick();
        n_tests++;
        if (phase_err !== 1'b1 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL err_invalid: actual %s, required %s", fmt({leds, dir, busy, load_ack, phase_err, step_count}), fmt(mdl_vec()));
        end
        advance();
        n_tests++;
        if (step_count !== 8'd3 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL err_resync: actual %s, required cnt=3 (%s)", fmt({leds, dir, busy, load_ack, phase_err, step_count}), fmt(mdl_vec()));
        end
        err_clear = 1; tick(); err_clear = 0;
        n_tests++;
        if (phase_err !== 1'b0 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL err_clear: actual err=%b, required 0", phase_err);
        end
    endtask

    task automatic test_control();
        mode = 0; load_pattern = 8'h0F; load = 1;
        for (int i = 0; i < 2; i++) begin
            advance();
            n_tests++;
            if (load_ack !== 1'b0 || busy !== 1'b1 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
                n_fail++;
                $display("FAIL ctrl_run_load%0d: actual %s, required %s", i, fmt({leds, dir, busy, load_ack, phase_err, step_count}), fmt(mdl_vec()));
            end
        end
        stop = 1; tick(); stop = 0;
        n_tests++;
        if (busy !== 1'b0 || load_ack !== 1'b0 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL ctrl_stop: actual %s, required busy=0 ack=0", fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
        tick();
        n_tests++;
        if (load_ack !== 1'b1 || leds !== 8'h0F || step_count !== 8'd0 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL ctrl_pause_load: actual %s, required leds=0f ack=1 cnt=0", fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
        load = 0;
        start = 1; tick(); start = 0;
        stop = 1; tick();
        start = 1; tick();
        n_tests++;
        if (busy !== 1'b0 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL ctrl_start_stop: actual busy=%b, required 0", busy);
        end
        stop = 0; tick(); start = 0;
        n_tests++;
        if (busy !== 1'b1 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL ctrl_resume: actual busy=%b, required 1", busy);
        end
    endtask

    task automatic test_load_once();
        int acks;
        stop = 1; tick(); stop = 0;
        load_pattern = 8'h00; load = 1; tick(); load = 0; tick();
        start = 1; tick(); start = 0;
        n_tests++;
        if (busy !== 1'b0 || leds !== 8'h00 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL zero_start: actual %s, required leds=00 busy=0", fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
        acks = 0;
        load_pattern = 8'h3C; load = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(load_ack);
        end
        load = 0; tick();
        n_tests++;
        if (acks !== 1 || leds !== 8'h3C) begin
            n_fail++;
            $display("FAIL load_once: actual acks=%0d leds=%h, required acks=1 leds=3c", acks, leds);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1; tick(); start = 0;
        advance(); advance();
        n_tests++;
        if ({leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL rst_pre: actual %s, required %s", fmt({leds, dir, busy, load_ack, phase_err, step_count}), fmt(mdl_vec()));
        end
        cur_ph = (cur_ph + 1) % 3;
        set_phase(cur_ph);
        sync_reset = 1; tick(); sync_reset = 0;
        n_tests++;
        if ({leds, dir, busy, load_ack, phase_err, step_count} !== {8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_run: actual %s, required leds=01 dir=0 busy=0 ack=0 err=0 cnt=0",
                     fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
        advance();
        n_tests++;
        if (leds !== 8'h01 || step_count !== 8'd0 || busy !== 1'b0 || {leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
            n_fail++;
            $display("FAIL rst_resync: actual %s, required leds=01 cnt=0 busy=0", fmt({leds, dir, busy, load_ack, phase_err, step_count}));
        end
    endtask

    task automatic test_random();
        int r, p;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                cur_ph = (cur_ph + 1) % 3;
                set_phase(cur_ph);
            end else if (r < 80) begin
                p = $urandom_range(0, 4);
                set_phase(p);
                if (p < 3) cur_ph = p;
            end
            start        = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 15) == 0);
            load         = ($urandom_range(0, 5) == 0);
            load_pattern = 8'($urandom);
            mode         = 1'($urandom);
            dir_in       = 1'($urandom);
            err_clear    = ($urandom_range(0, 9) == 0);
            sync_reset   = ($urandom_range(0, 99) == 0);
            tick();
            n_tests++;
            if ({leds, dir, busy, load_ack, phase_err, step_count} !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: actual %s, required %s", i,
                         fmt({leds, dir, busy, load_ack, phase_err, step_count}), fmt(mdl_vec()));
            end
        end
        start = 0; stop = 0; load = 0; err_clear = 0; sync_reset = 0;
    endtask

    initial begin
        sync_reset = 1; start = 0; stop = 0; mode = 0; dir_in = 0;
        load = 0; load_pattern = '0; err_clear = 0; cur_ph = 0;
        set_phase(0);
        test_reset();
        test_rotate();
        test_bounce();
        test_phase_err();
        test_control();
        test_load_once();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
